// File: rtl/elevator_pkg.sv
// Shared floor encodings, dwell FSM states and sizing helpers for the elevator request queue.
// Included by the queue top and its combinational compaction stage.
package elevator_pkg;

  localparam int LVL_W = 2;

  localparam logic [LVL_W-1:0] FLOOR_A = 2'b00;
  localparam logic [LVL_W-1:0] FLOOR_B = 2'b01;
  localparam logic [LVL_W-1:0] FLOOR_C = 2'b10;
  localparam logic [LVL_W-1:0] FLOOR_D = 2'b11;
  localparam logic [LVL_W-1:0] PAD_LVL = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  // tail counts 0..depth inclusive, hence depth+1 states
  function automatic int tail_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elevator_request_queue_compact.sv
// Removes the entry equal to lvl_i from a packed queue, shifting higher slots toward the head.
// Purely combinational; no backpressure.
module queue_compact
  import elevator_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = elevator_pkg::LVL_W
) (
  input  logic [DEPTH*LVL_W-1:0]   queue_i,
  input  logic [tail_w(DEPTH)-1:0] tail_i,
  input  logic [LVL_W-1:0]         lvl_i,
  output logic [DEPTH*LVL_W-1:0]   queue_o,
  output logic [tail_w(DEPTH)-1:0] tail_o,
  output logic                     hit_o
);

  localparam int TAIL_W = tail_w(DEPTH);

  logic [DEPTH*LVL_W-1:0] shifted;
  int                     hit_idx;

  always_comb begin
    hit_idx = DEPTH;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((TAIL_W'(i) < tail_i) && (queue_i[i*LVL_W +: LVL_W] == lvl_i)) begin
        hit_idx = i;
      end
    end
    hit_o = (hit_idx < DEPTH);

    // Top slot is always refilled with padding since entries never duplicate.
    shifted = {{LVL_W{1'b1}}, queue_i[DEPTH*LVL_W-1:LVL_W]};

    queue_o = queue_i;
    tail_o  = tail_i;
    if (hit_o) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j >= hit_idx) begin
          queue_o[j*LVL_W +: LVL_W] = shifted[j*LVL_W +: LVL_W];
        end
      end
      tail_o = tail_i - TAIL_W'(1);
    end
  end

endmodule

// File: rtl/elevator_request_queue.sv
// Floor-request queue with duplicate suppression and door-dwell FSM; all outputs registered (1 edge).
// req_ready drops only when full; ELEVATOR_QUEUE_OVF_STICKY_EN adds a sticky refused-request flag.
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int LVL_W        = elevator_pkg::LVL_W,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [LVL_W-1:0]         req_lvl,
  output logic                     req_ready,
  input  logic                     arrive_valid,
  input  logic [LVL_W-1:0]         pos_lvl,
  output logic [DEPTH*LVL_W-1:0]   queue_out,
  output logic [tail_w(DEPTH)-1:0] tail_out,
  output logic                     head_valid,
  output logic                     door_open,
  output logic                     req_dup
`ifdef ELEVATOR_QUEUE_OVF_STICKY_EN
  ,
  input  logic                     ovf_clear,
  output logic                     ovf_sticky
`endif
);

  localparam int TAIL_W = tail_w(DEPTH);
  localparam int CNT_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [DEPTH*LVL_W-1:0] queue_q, queue_d, queue_a, cmp_queue;
  logic [TAIL_W-1:0]      tail_q, tail_d, tail_a, cmp_tail;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_dup_q, req_dup_d;
  logic                   cmp_hit, remove, accept, dup;

  queue_compact #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_compact (
    .queue_i (queue_q),
    .tail_i  (tail_q),
    .lvl_i   (pos_lvl),
    .queue_o (cmp_queue),
    .tail_o  (cmp_tail),
    .hit_o   (cmp_hit)
  );

  assign remove = (state_q == IDLE) && arrive_valid && cmp_hit;
  assign accept = req_valid && req_ready;

  always_comb begin
    queue_a = remove ? cmp_queue : queue_q;
    tail_a  = remove ? cmp_tail : tail_q;

    // The floor being served this edge counts as present for dedup.
    dup = remove && (req_lvl == pos_lvl);
    for (int i = 0; i < DEPTH; i++) begin
      if ((TAIL_W'(i) < tail_a) && (queue_a[i*LVL_W +: LVL_W] == req_lvl)) begin
        dup = 1'b1;
      end
    end

    queue_d   = queue_a;
    tail_d    = tail_a;
    req_dup_d = 1'b0;
    if (accept) begin
      if (dup) begin
        req_dup_d = 1'b1;
      end else begin
        for (int j = 0; j < DEPTH; j++) begin
          if (TAIL_W'(j) == tail_a) begin
            queue_d[j*LVL_W +: LVL_W] = req_lvl;
          end
        end
        tail_d = tail_a + TAIL_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (remove) begin
          state_d = DWELL;
          cnt_d   = CNT_W'(DWELL_CYCLES - 1);
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      queue_q   <= '1;
      tail_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_dup_q <= 1'b0;
    end else begin
      queue_q   <= queue_d;
      tail_q    <= tail_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_dup_q <= req_dup_d;
    end
  end

`ifdef ELEVATOR_QUEUE_OVF_STICKY_EN
  logic ovf_sticky_q, ovf_sticky_d;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (req_valid && !req_ready) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

  assign req_ready  = (tail_q != TAIL_W'(DEPTH));
  assign queue_out  = queue_q;
  assign tail_out   = tail_q;
  assign head_valid = (tail_q != '0);
  assign door_open  = (state_q == DWELL);
  assign req_dup    = req_dup_q;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed self-checking bench for elevator_request_queue (default DEPTH=4, LVL_W=2, DWELL_CYCLES=8).
// Build with ELEVATOR_QUEUE_OVF_STICKY_EN defined to also exercise the sticky overflow flag.
module tb_elevator_request_queue;

  localparam logic [1:0] LA = 2'b00;
  localparam logic [1:0] LB = 2'b01;
  localparam logic [1:0] LC = 2'b10;
  localparam logic [1:0] LD = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_lvl = 2'b00;
  logic       req_ready;
  logic       arrive_valid = 1'b0;
  logic [1:0] pos_lvl = 2'b00;
  logic [7:0] queue_out;
  logic [2:0] tail_out;
  logic       head_valid;
  logic       door_open;
  logic       req_dup;
`ifdef ELEVATOR_QUEUE_OVF_STICKY_EN
  logic       ovf_clear = 1'b0;
  logic       ovf_sticky;
`endif

  int checks = 0;
  int errors = 0;

  elevator_request_queue dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_lvl      (req_lvl),
    .req_ready    (req_ready),
    .arrive_valid (arrive_valid),
    .pos_lvl      (pos_lvl),
    .queue_out    (queue_out),
    .tail_out     (tail_out),
    .head_valid   (head_valid),
    .door_open    (door_open),
    .req_dup      (req_dup)
`ifdef ELEVATOR_QUEUE_OVF_STICKY_EN
    ,
    .ovf_clear    (ovf_clear),
    .ovf_sticky   (ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    arrive_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic enq(input logic [1:0] lvl);
    req_valid = 1'b1;
    req_lvl = lvl;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (queue_out !== 8'hFF) begin errors++; $display("FAIL reset_queue got %h want %h", queue_out, 8'hFF); end
    checks++; if (tail_out !== 3'd0) begin errors++; $display("FAIL reset_tail got %0d want 0", tail_out); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (door_open !== 1'b0 || req_dup !== 1'b0 || head_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags door=%b dup=%b head=%b want 0 0 0", door_open, req_dup, head_valid);
    end
`ifdef ELEVATOR_QUEUE_OVF_STICKY_EN
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_sticky); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_enqueue();
    do_reset();
    enq(LB);
    enq(LA);
    enq(LD);
    checks++; if (queue_out !== 8'hF1) begin errors++; $display("FAIL enq_queue got %h want %h", queue_out, 8'hF1); end
    checks++; if (tail_out !== 3'd3) begin errors++; $display("FAIL enq_tail got %0d want 3", tail_out); end
    checks++; if (req_ready !== 1'b1 || head_valid !== 1'b1) begin
      errors++; $display("FAIL enq_ready ready=%b head=%b want 1 1", req_ready, head_valid);
    end
  endtask

  task automatic test_full_hold();
    do_reset();
    enq(LC);
    enq(LB);
    enq(LA);
    enq(LD);
    checks++; if (queue_out !== 8'hC6 || tail_out !== 3'd4) begin
      errors++; $display("FAIL full_fill queue=%h tail=%0d want c6 4", queue_out, tail_out);
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", req_ready); end
    req_valid = 1'b1;
    req_lvl = LA;
    repeat (3) tick();
    checks++; if (queue_out !== 8'hC6 || tail_out !== 3'd4 || req_dup !== 1'b0) begin
      errors++; $display("FAIL full_hold queue=%h tail=%0d dup=%b want c6 4 0", queue_out, tail_out, req_dup);
    end
`ifdef ELEVATOR_QUEUE_OVF_STICKY_EN
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf_sticky); end
    ovf_clear = 1'b1;
    tick();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set_priority got %b want 1", ovf_sticky); end
    req_valid = 1'b0;
    tick();
    ovf_clear = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf_sticky); end
`endif
    req_valid = 1'b0;
  endtask

  // Continues from the full C,B,A,D queue left by test_full_hold.
  task automatic test_arrive_dwell();
    logic exp_door;
    arrive_valid = 1'b1;
    pos_lvl = LC;
    tick();
    arrive_valid = 1'b0;
    checks++; if (queue_out !== 8'hF1 || tail_out !== 3'd3) begin
      errors++; $display("FAIL arrive_remove queue=%h tail=%0d want f1 3", queue_out, tail_out);
    end
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL dwell_cycle1 got %b want 1", door_open); end
    for (int k = 2; k <= 9; k++) begin
      if (k == 3) begin arrive_valid = 1'b1; pos_lvl = LB; end
      if (k == 5) begin req_valid = 1'b1; req_lvl = LC; end
      tick();
      arrive_valid = 1'b0;
      req_valid = 1'b0;
      exp_door = (k <= 8);
      checks++; if (door_open !== exp_door) begin
        errors++; $display("FAIL dwell_cycle%0d got %b want %b", k, door_open, exp_door);
      end
    end
    checks++; if (queue_out !== 8'hB1 || tail_out !== 3'd4) begin
      errors++; $display("FAIL dwell_ignore_insert queue=%h tail=%0d want b1 4", queue_out, tail_out);
    end
  endtask

  task automatic test_miss_dup();
    do_reset();
    enq(LB);
    enq(LA);
    arrive_valid = 1'b1;
    pos_lvl = LC;
    tick();
    arrive_valid = 1'b0;
    tick();
    checks++; if (queue_out !== 8'hF1 || tail_out !== 3'd2 || door_open !== 1'b0) begin
      errors++; $display("FAIL arrive_miss queue=%h tail=%0d door=%b want f1 2 0", queue_out, tail_out, door_open);
    end
    enq(LA);
    checks++; if (req_dup !== 1'b1 || queue_out !== 8'hF1 || tail_out !== 3'd2) begin
      errors++; $display("FAIL dup_drop dup=%b queue=%h tail=%0d want 1 f1 2", req_dup, queue_out, tail_out);
    end
    tick();
    checks++; if (req_dup !== 1'b0) begin errors++; $display("FAIL dup_pulse got %b want 0", req_dup); end
  endtask

  // Continues from the B,A queue left by test_miss_dup.
  task automatic test_simul_dup();
    arrive_valid = 1'b1;
    pos_lvl = LB;
    req_valid = 1'b1;
    req_lvl = LB;
    tick();
    arrive_valid = 1'b0;
    req_valid = 1'b0;
    checks++; if (queue_out !== 8'hFC || tail_out !== 3'd1) begin
      errors++; $display("FAIL simul_dup_queue queue=%h tail=%0d want fc 1", queue_out, tail_out);
    end
    checks++; if (req_dup !== 1'b1 || door_open !== 1'b1) begin
      errors++; $display("FAIL simul_dup_flags dup=%b door=%b want 1 1", req_dup, door_open);
    end
    repeat (8) tick();
    checks++; if (door_open !== 1'b0 || req_dup !== 1'b0) begin
      errors++; $display("FAIL simul_dup_end door=%b dup=%b want 0 0", door_open, req_dup);
    end
  endtask

  task automatic test_simul_insert();
    do_reset();
    enq(LB);
    enq(LA);
    arrive_valid = 1'b1;
    pos_lvl = LA;
    req_valid = 1'b1;
    req_lvl = LC;
    tick();
    arrive_valid = 1'b0;
    req_valid = 1'b0;
    checks++; if (queue_out !== 8'hF9 || tail_out !== 3'd2 || req_dup !== 1'b0) begin
      errors++; $display("FAIL simul_insert queue=%h tail=%0d dup=%b want f9 2 0", queue_out, tail_out, req_dup);
    end
  endtask

  task automatic test_reset_dwell();
    do_reset();
    enq(LB);
    enq(LA);
    arrive_valid = 1'b1;
    pos_lvl = LB;
    tick();
    arrive_valid = 1'b0;
    tick();
    tick();
    checks++; if (door_open !== 1'b1 || queue_out !== 8'hFC || tail_out !== 3'd1) begin
      errors++; $display("FAIL pre_reset door=%b queue=%h tail=%0d want 1 fc 1", door_open, queue_out, tail_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (door_open !== 1'b0 || tail_out !== 3'd0 || queue_out !== 8'hFF || req_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset door=%b tail=%0d queue=%h ready=%b want 0 0 ff 1",
                         door_open, tail_out, queue_out, req_ready);
    end
    rst = 1'b0;
    tick();
    arrive_valid = 1'b1;
    pos_lvl = LA;
    tick();
    arrive_valid = 1'b0;
    checks++; if (door_open !== 1'b0 || tail_out !== 3'd0 || queue_out !== 8'hFF) begin
      errors++; $display("FAIL empty_arrive door=%b tail=%0d queue=%h want 0 0 ff", door_open, tail_out, queue_out);
    end
  endtask

  initial begin
    test_reset();
    test_enqueue();
    test_full_hold();
    test_arrive_dwell();
    test_miss_dup();
    test_simul_dup();
    test_simul_insert();
    test_reset_dwell();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
